// File: rtl/rf_wb_ctrl.sv
// Write-back arbiter and long-latency scoreboard in front of the register file write port.
// EX wins the port; a displaced long-unit result waits in a one-entry buffer until EX is idle.
module rf_wb_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_wen,
    input  logic        issue_long,
    output logic        issue_stall,
    input  logic        ex_wen,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        lu_valid,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    output logic        wb_hold,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [31:1]   busy;
    logic [CW-1:0] out_cnt;
    logic          buf_valid;
    logic [4:0]    buf_waddr;
    logic [31:0]   buf_wdata;
    logic [SW-1:0] starve_cnt;

    logic [31:0]   busy_vec;
    logic [31:1]   busy_nxt;
    logic          ex_act;
    logic          lu_acc;
    logic          lu_direct;
    logic          lu_to_buf;
    logic          buf_drain;
    logic          commit;
    logic [4:0]    commit_addr;
    logic          issue_set;
    logic          hz1, hz2, hzd, full;

    assign busy_vec  = {busy, 1'b0};
    assign ex_act    = rstn & ex_wen;
    assign lu_ready  = rstn & ~buf_valid;
    assign lu_acc    = lu_valid & lu_ready;
    assign lu_direct = lu_acc & ~ex_wen;
    assign lu_to_buf = lu_acc & ex_wen;
    assign buf_drain = rstn & buf_valid & ~ex_wen;

    assign commit      = (buf_drain && buf_waddr != 5'd0) || (lu_direct && lu_waddr != 5'd0);
    assign commit_addr = buf_drain ? buf_waddr : lu_waddr;

    // Hazards look only at registered busy, so a commit unstalls one cycle later.
    assign hz1  = (issue_rs1 != 5'd0) && busy_vec[issue_rs1];
    assign hz2  = (issue_rs2 != 5'd0) && busy_vec[issue_rs2];
    assign hzd  = issue_rd_wen && (issue_rd != 5'd0) && busy_vec[issue_rd];
    assign full = issue_long && (out_cnt == CW'(MAX_OUTSTANDING));

    assign issue_stall = rstn & issue_valid & (hz1 | hz2 | hzd | full);
    assign issue_set   = rstn & issue_valid & ~issue_stall & issue_long & issue_rd_wen
                         & (issue_rd != 5'd0);

    assign wb_hold = rstn & buf_valid & (starve_cnt >= SW'(STARVE_LIMIT));

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (ex_act) begin
            rf_wen   = (ex_waddr != 5'd0);
            rf_waddr = ex_waddr;
            rf_wdata = ex_wdata;
        end else if (buf_drain) begin
            rf_wen   = (buf_waddr != 5'd0);
            rf_waddr = buf_waddr;
            rf_wdata = buf_wdata;
        end else if (lu_direct) begin
            rf_wen   = (lu_waddr != 5'd0);
            rf_waddr = lu_waddr;
            rf_wdata = lu_wdata;
        end
    end

    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < 32; i++) begin
            if (commit && commit_addr == 5'(i))
                busy_nxt[i] = 1'b0;
            if (issue_set && issue_rd == 5'(i))
                busy_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy       <= '0;
            out_cnt    <= '0;
            buf_valid  <= 1'b0;
            buf_waddr  <= 5'd0;
            buf_wdata  <= 32'd0;
            starve_cnt <= '0;
        end else begin
            busy <= busy_nxt;

            case ({issue_set, commit})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase

            if (lu_to_buf) begin
                buf_valid <= 1'b1;
                buf_waddr <= lu_waddr;
                buf_wdata <= lu_wdata;
            end else if (buf_drain) begin
                buf_valid <= 1'b0;
            end

            // Saturates so wb_hold stays up for as long as the buffer keeps losing.
            if (buf_valid && ex_wen) begin
                if (starve_cnt < SW'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule
